// File: rtl/aska_bbm.sv
// aska_bbm -- break-before-make sequencer for the stimulation H bridge.
// Holds the applied switch pattern and moves to a new request without ever
// closing a switch while its opposite-bank partner may still be closed.
// Optional build macro: ASKA_BBM_FAULT_EN. When defined, shoot-through
// requests latch a fault. When undefined, conflicting bit pairs are masked off.
module aska_bbm #(
    parameter int DEAD_W = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       up_req,
    input  logic [31:0]       down_req,
    input  logic [5:0]        dac_req,
    input  logic              pulse_active_in,
    input  logic [DEAD_W-1:0] dead_cycles,
    input  logic              clear_fault,
    output logic [31:0]       up_switches,
    output logic [31:0]       down_switches,
    output logic [5:0]        DAC,
    output logic              pulse_active,
    output logic              fault
);

`ifdef ASKA_BBM_FAULT_EN
    typedef enum logic [1:0] {STABLE, BREAK, FAULT} state_t;
`else
    typedef enum logic [1:0] {STABLE, BREAK} state_t;
`endif

    state_t            state, state_nxt;
    logic [31:0]       tgt_up, tgt_dn, tgt_up_nxt, tgt_dn_nxt;
    logic [31:0]       up_nxt, dn_nxt;
    logic [5:0]        dac_nxt;
    logic              pa_nxt, fault_nxt;
    logic [DEAD_W-1:0] cnt, cnt_nxt;

    logic [31:0] conflict;
    logic [31:0] req_up, req_dn;
    logic        chg_app, chg_tgt;

    assign conflict = up_req & down_req;

`ifdef ASKA_BBM_FAULT_EN
    logic shoot;
    assign shoot  = |conflict;
    assign req_up = up_req;
    assign req_dn = down_req;
`else
    // Conflicting pairs are simply dropped from both banks.
    logic unused_clear_fault;
    assign unused_clear_fault = clear_fault;
    assign req_up = up_req & ~conflict;
    assign req_dn = down_req & ~conflict;
`endif

    assign chg_app = (req_up != up_switches) || (req_dn != down_switches);
    assign chg_tgt = (req_up != tgt_up) || (req_dn != tgt_dn);

    // Next-state and next-output logic; every register defaults to hold.
    always_comb begin
        state_nxt  = state;
        up_nxt     = up_switches;
        dn_nxt     = down_switches;
        dac_nxt    = DAC;
        pa_nxt     = pulse_active;
        fault_nxt  = fault;
        tgt_up_nxt = tgt_up;
        tgt_dn_nxt = tgt_dn;
        cnt_nxt    = cnt;

        case (state)
            STABLE: begin
                tgt_up_nxt = req_up;
                tgt_dn_nxt = req_dn;
                if (chg_app && dead_cycles != '0) begin
                    // Open the switches that turn off; close nothing yet.
                    up_nxt    = up_switches & req_up;
                    dn_nxt    = down_switches & req_dn;
                    dac_nxt   = '0;
                    pa_nxt    = 1'b0;
                    cnt_nxt   = dead_cycles;
                    state_nxt = BREAK;
                end else begin
                    up_nxt  = req_up;
                    dn_nxt  = req_dn;
                    dac_nxt = dac_req;
                    pa_nxt  = pulse_active_in;
                end
            end
            BREAK: begin
                if (chg_tgt) begin
                    // Target moved: restart the dead time from the current setting.
                    tgt_up_nxt = req_up;
                    tgt_dn_nxt = req_dn;
                    if (dead_cycles == '0) begin
                        up_nxt    = req_up;
                        dn_nxt    = req_dn;
                        dac_nxt   = dac_req;
                        pa_nxt    = pulse_active_in;
                        cnt_nxt   = '0;
                        state_nxt = STABLE;
                    end else begin
                        up_nxt  = up_switches & req_up;
                        dn_nxt  = down_switches & req_dn;
                        cnt_nxt = dead_cycles;
                    end
                end else if (cnt <= DEAD_W'(1)) begin
                    up_nxt    = tgt_up;
                    dn_nxt    = tgt_dn;
                    dac_nxt   = dac_req;
                    pa_nxt    = pulse_active_in;
                    cnt_nxt   = '0;
                    state_nxt = STABLE;
                end else begin
                    cnt_nxt = cnt - DEAD_W'(1);
                end
            end
`ifdef ASKA_BBM_FAULT_EN
            FAULT: begin
                up_nxt  = '0;
                dn_nxt  = '0;
                dac_nxt = '0;
                pa_nxt  = 1'b0;
                if (clear_fault && !shoot) begin
                    fault_nxt  = 1'b0;
                    tgt_up_nxt = '0;
                    tgt_dn_nxt = '0;
                    state_nxt  = STABLE;
                end
            end
`endif
            default: begin
                state_nxt = STABLE;
            end
        endcase

`ifdef ASKA_BBM_FAULT_EN
        // Shoot-through overrides everything outside FAULT.
        if (state != FAULT && shoot) begin
            up_nxt     = '0;
            dn_nxt     = '0;
            dac_nxt    = '0;
            pa_nxt     = 1'b0;
            tgt_up_nxt = '0;
            tgt_dn_nxt = '0;
            cnt_nxt    = '0;
            fault_nxt  = 1'b1;
            state_nxt  = FAULT;
        end
`else
        fault_nxt = 1'b0;
`endif
    end

    // State and output registers; reset drops every switch open immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= STABLE;
            up_switches   <= '0;
            down_switches <= '0;
            DAC           <= '0;
            pulse_active  <= 1'b0;
            fault         <= 1'b0;
            tgt_up        <= '0;
            tgt_dn        <= '0;
            cnt           <= '0;
        end else begin
            state         <= state_nxt;
            up_switches   <= up_nxt;
            down_switches <= dn_nxt;
            DAC           <= dac_nxt;
            pulse_active  <= pa_nxt;
            fault         <= fault_nxt;
            tgt_up        <= tgt_up_nxt;
            tgt_dn        <= tgt_dn_nxt;
            cnt           <= cnt_nxt;
        end
    end

endmodule
